// File: rtl/reg_exec_pkg.sv
// Shared definitions for the execute/write-back controller: opcodes, FSM states and
// register-index width.
package reg_exec_pkg;

  localparam int unsigned RegIdxW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes the result of one opcode and reports whether the
// opcode affects the carry flag.
module alu_core #(
  parameter int unsigned W = 8
) (
  input  logic [2:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         carry_upd
);
  import reg_exec_pkg::*;

  logic [W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    carry_upd = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        result    = sum[W-1:0];
        carry_out = sum[W];
        carry_upd = 1'b1;
      end
      OP_SUB: begin
        result    = a - b;
        carry_out = (a < b);
        carry_upd = 1'b1;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result    = {a[W-2:0], 1'b0};
        carry_out = a[W-1];
        carry_upd = 1'b1;
      end
      OP_MOV: result = a;
      OP_LDI: result = imm;
    endcase
  end

endmodule

// File: rtl/reg_exec_unit.sv
// Four-state execute/write-back controller that owns all register-file control:
// read selects, operand latch, ALU, and a single-cycle write strobe.
module reg_exec_unit
  import reg_exec_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [2:0]         opcode,
  input  logic [RegIdxW-1:0] src1,
  input  logic [RegIdxW-1:0] src2,
  input  logic [RegIdxW-1:0] dest,
  input  logic [W-1:0]       imm,
  input  logic [W-1:0]       read_data1,
  input  logic [W-1:0]       read_data2,
  output logic [RegIdxW-1:0] src_sel1,
  output logic [RegIdxW-1:0] src_sel2,
  output logic [RegIdxW-1:0] dest_sel,
  output logic               wrt_enable,
  output logic [W-1:0]       wrt_data,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               done
);

  state_e state_q, state_d;

  logic               accept;
  logic               ready_d;
  logic               wb_d;
  logic [2:0]         op_q;
  logic [RegIdxW-1:0] dest_q;
  logic [W-1:0]       imm_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       alu_result;
  logic               alu_carry;
  logic               alu_carry_upd;

  assign accept = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRead;
      StRead: state_d = StExec;
      StExec: state_d = StWb;
      StWb:   state_d = StIdle;
    endcase
    // Ready and strobes are registered, so derive them from the upcoming state.
    ready_d = (state_d == StIdle);
    wb_d    = (state_d == StWb);
  end

  alu_core #(
    .W(W)
  ) u_alu (
    .opcode    (op_q),
    .a         (a_q),
    .b         (b_q),
    .imm       (imm_q),
    .result    (alu_result),
    .carry_out (alu_carry),
    .carry_upd (alu_carry_upd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_ready <= 1'b0;
      op_q        <= '0;
      dest_q      <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      src_sel1    <= '0;
      src_sel2    <= '0;
      dest_sel    <= '0;
      wrt_enable  <= 1'b0;
      wrt_data    <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
      done        <= 1'b0;
    end else begin
      instr_ready <= ready_d;
      wrt_enable  <= wb_d;
      done        <= wb_d;
      if (accept) begin
        op_q     <= opcode;
        dest_q   <= dest;
        imm_q    <= imm;
        src_sel1 <= src1;
        src_sel2 <= src2;
      end
      if (state_q == StRead) begin
        a_q <= read_data1;
        b_q <= read_data2;
      end
      if (state_q == StExec) begin
        wrt_data  <= alu_result;
        dest_sel  <= dest_q;
        zero_flag <= (alu_result == '0);
        if (alu_carry_upd) carry_flag <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_reg_exec_unit.sv
// Scoreboard bench: behavioural register file, ISA-level reference model computed at
// accept time, and an independent write-back monitor.
module tb_reg_exec_unit;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, MOV = 3'd6, LDI = 3'd7;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [3:0] src1, src2, dest;
  logic [7:0] imm;
  logic [7:0] read_data1, read_data2;
  logic [3:0] src_sel1, src_sel2, dest_sel;
  logic       wrt_enable;
  logic [7:0] wrt_data;
  logic       zero_flag, carry_flag, done;

  logic [7:0] rf     [16] = '{default: 8'h00};
  logic [7:0] ref_rf [16] = '{default: 8'h00};
  logic       mdl_zero  = 1'b0;
  logic       mdl_carry = 1'b0;

  typedef struct {
    logic [3:0] dest;
    logic [7:0] data;
    logic       zero;
    logic       carry;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   prev_acc = 0;

  reg_exec_unit #(
    .W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .imm         (imm),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .src_sel1    (src_sel1),
    .src_sel2    (src_sel2),
    .dest_sel    (dest_sel),
    .wrt_enable  (wrt_enable),
    .wrt_data    (wrt_data),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: combinational reads, write on the clock edge.
  assign read_data1 = rf[src_sel1];
  assign read_data2 = rf[src_sel2];
  always @(posedge clk) if (wrt_enable) rf[dest_sel] <= wrt_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns {carry, zero, result} by the ISA rules in plain integer arithmetic.
  function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] im,
                                       input logic cin);
    int ai = int'(a);
    int bi = int'(b);
    int r;
    logic c = cin;
    case (op)
      ADD:  begin r = ai + bi; c = (r > 255); end
      SUB:  begin r = ai - bi; c = (ai < bi); end
      AND_: r = int'(a & b);
      OR_:  r = int'(a | b);
      XOR_: r = int'(a ^ b);
      SHL:  begin r = ai * 2; c = (ai > 127); end
      MOV:  r = ai;
      default: r = int'(im);
    endcase
    r = r & 255;
    return {c, (r == 0), r[7:0]};
  endfunction

  // Acceptor: the handshake completes at the next edge; predict the write-back.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      exp_t       e;
      logic [9:0] m;
      m = model(opcode, ref_rf[src1], ref_rf[src2], imm, mdl_carry);
      e.dest  = dest;
      e.data  = m[7:0];
      e.zero  = m[8];
      e.carry = m[9];
      e.cyc   = cyc + 3;
      sb.push_back(e);
      prev_acc = last_acc;
      last_acc = cyc;
    end
  end

  // Monitor: compare every write-back and commit it to the reference state.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      sb.delete();
      mdl_zero  = 1'b0;
      mdl_carry = 1'b0;
    end else if (wrt_enable) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {28'h0, dest_sel}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_dest", dest_sel, e.dest);
        check("wb_data", wrt_data, e.data);
        check("wb_zero", zero_flag, e.zero);
        check("wb_carry", carry_flag, e.carry);
        check("wb_done", done, 1'b1);
        check("wb_cycle", e.cyc, cyc);
        ref_rf[e.dest] = e.data;
        mdl_zero       = e.zero;
        mdl_carry      = e.carry;
      end
    end else if (done) begin
      check("done_without_write", done, 1'b0);
    end
  end

  // All tasks start and end at posedge + 1.
  task automatic issue(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [7:0] im, input bit hold);
    bit got = 1'b0;
    opcode = op; src1 = s1; src2 = s2; dest = d; imm = im;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_ready) got = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
    end else if (!hold) begin
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      if (sb.size() == 0 && instr_ready) break;
      @(posedge clk);
      #1;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic expect_state(input string name, input int idx, input logic [7:0] val,
                              input logic z, input logic c);
    drain();
    @(negedge clk);
    check(name, rf[idx], val);
    check({name, "_zero"}, zero_flag, z);
    check({name, "_carry"}, carry_flag, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'($urandom);
      opcode = 3'($urandom); src1 = 4'($urandom); src2 = 4'($urandom);
      dest = 4'($urandom); imm = 8'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("reset_outputs", {src_sel1, src_sel2, dest_sel, wrt_enable, wrt_data, zero_flag,
                            carry_flag, done}, 0);
    check("reset_ready", instr_ready, 1'b0);
    instr_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check("ready_before_edge", instr_ready, 1'b0);
    @(posedge clk);
    #1 check("ready_after_edge", instr_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; instr_valid = 1'b0;
    opcode = '0; src1 = '0; src2 = '0; dest = '0; imm = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    issue(LDI, 0, 0, 3, 8'h5A, 0);
    issue(ADD, 3, 3, 4, 0, 0);
    expect_state("add_r4", 4, 8'hB4, 0, 0);

    issue(LDI, 0, 0, 1, 8'h10, 0);
    issue(LDI, 0, 0, 2, 8'h20, 0);
    issue(SUB, 1, 2, 5, 0, 0);
    expect_state("sub_r5", 5, 8'hF0, 0, 1);
    issue(LDI, 0, 0, 6, 8'hFF, 0);
    issue(LDI, 0, 0, 7, 8'h01, 0);
    issue(ADD, 6, 7, 8, 0, 0);
    expect_state("add_r8", 8, 8'h00, 1, 1);

    issue(LDI, 0, 0, 1, 8'hC3, 0);
    issue(LDI, 0, 0, 2, 8'h5A, 0);
    issue(AND_, 1, 2, 10, 0, 0);
    expect_state("and_r10", 10, 8'h42, 0, 1);
    issue(OR_, 1, 2, 11, 0, 0);
    expect_state("or_r11", 11, 8'hDB, 0, 1);
    issue(XOR_, 1, 2, 12, 0, 0);
    expect_state("xor_r12", 12, 8'h99, 0, 1);
    issue(ADD, 2, 2, 0, 0, 0);
    expect_state("add_r0", 0, 8'hB4, 0, 0);
    issue(SHL, 1, 0, 13, 0, 0);
    expect_state("shl_r13", 13, 8'h86, 0, 1);
    issue(MOV, 13, 0, 14, 0, 0);
    expect_state("mov_r14", 14, 8'h86, 0, 1);

    issue(LDI, 0, 0, 15, 8'h33, 1);
    issue(ADD, 15, 15, 14, 0, 0);
    check("b2b_spacing", last_acc - prev_acc, 4);
    expect_state("raw_r14", 14, 8'h66, 0, 0);

    issue(ADD, 1, 2, 9, 0, 0);
    @(posedge clk);
    #1;
    do_reset(2);
    check("abort_r9", rf[9], 8'h00);
    issue(LDI, 0, 0, 9, 8'h77, 0);
    expect_state("after_abort_r9", 9, 8'h77, 0, 0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
            8'($urandom), 1'($urandom));
    end
    instr_valid = 1'b0;
    drain();
    @(negedge clk);
    for (int i = 0; i < 16; i++) check("rf_final", rf[i], ref_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
